// File: rtl/hazard_stall_ctrl.sv
// Stall/flush/halt control for PC, IF_ID, ID_EX and EX_MEM registers.
// Optional stall-cycle counter built only when STALL_COUNT_EN is defined.
module hazard_stall_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int REG_ADDR_W        = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  idex_memtoreg,
  input  logic                  idex_regwrite,
  input  logic [REG_ADDR_W-1:0] idex_rd,
  input  logic [REG_ADDR_W-1:0] ifid_rs,
  input  logic [REG_ADDR_W-1:0] ifid_rt,
  input  logic                  ifid_uses_rs,
  input  logic                  ifid_uses_rt,
  input  logic                  branch_taken,
  input  logic                  halt_id,
  input  logic                  mem_busy,
  output logic                  pc_wen,
  output logic                  ifid_wen,
  output logic                  ifid_flush,
  output logic                  idex_wen,
  output logic                  idex_flush,
  output logic                  exmem_wen,
  output logic                  halted,
  output logic [15:0]           stall_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    HALT     = 2'd2
  } state_t;

  localparam logic [2:0] LU_INIT = 3'(LOAD_STALL_CYCLES - 1);
  localparam bit         LU_MULTI = (LOAD_STALL_CYCLES > 1);

  state_t     state, state_nx;
  logic [2:0] lu_cnt, lu_cnt_nx;
  logic       hz;
  logic       rs_hit, rt_hit;

  logic c_frz, c_br, c_hlt_st, c_lu, c_hlt_in, c_ld, c_go;

  logic pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w;

  assign rs_hit = ifid_uses_rs && (ifid_rs == idex_rd);
  assign rt_hit = ifid_uses_rt && (ifid_rt == idex_rd);
  assign hz = idex_memtoreg && idex_regwrite
           && (idex_rd != '0) && (rs_hit || rt_hit);

  // Mutually exclusive decode terms, priority folded in.
  assign c_frz    = mem_busy;
  assign c_br     = !mem_busy && branch_taken
                 && (state == RUN || state == LU_STALL);
  assign c_hlt_st = !mem_busy && (state == HALT);
  assign c_lu     = !mem_busy && !branch_taken
                 && (state == LU_STALL);
  assign c_hlt_in = !mem_busy && !branch_taken
                 && (state == RUN) && halt_id;
  assign c_ld     = !mem_busy && !branch_taken
                 && (state == RUN) && !halt_id && hz;
  assign c_go     = !mem_busy && !branch_taken
                 && (state == RUN) && !halt_id && !hz;

  always_comb begin
    state_nx  = state;
    lu_cnt_nx = lu_cnt;
    pc_w      = 1'b0;
    ifid_w    = 1'b0;
    ifid_f    = 1'b0;
    idex_w    = 1'b0;
    idex_f    = 1'b0;
    exmem_w   = 1'b0;
    unique case (1'b1)
      c_frz: begin
      end
      c_br: begin
        pc_w      = 1'b1;
        ifid_w    = 1'b1;
        ifid_f    = 1'b1;
        idex_w    = 1'b1;
        idex_f    = 1'b1;
        exmem_w   = 1'b1;
        state_nx  = RUN;
        lu_cnt_nx = 3'd0;
      end
      c_hlt_st: begin
        idex_w  = 1'b1;
        idex_f  = 1'b1;
        exmem_w = 1'b1;
      end
      c_lu: begin
        idex_w  = 1'b1;
        idex_f  = 1'b1;
        exmem_w = 1'b1;
        if (lu_cnt <= 3'd1) begin
          state_nx  = RUN;
          lu_cnt_nx = 3'd0;
        end else begin
          lu_cnt_nx = lu_cnt - 3'd1;
        end
      end
      c_hlt_in: begin
        idex_w   = 1'b1;
        idex_f   = 1'b1;
        exmem_w  = 1'b1;
        state_nx = HALT;
      end
      c_ld: begin
        idex_w  = 1'b1;
        idex_f  = 1'b1;
        exmem_w = 1'b1;
        if (LU_MULTI) begin
          state_nx  = LU_STALL;
          lu_cnt_nx = LU_INIT;
        end
      end
      c_go: begin
        pc_w    = 1'b1;
        ifid_w  = 1'b1;
        idex_w  = 1'b1;
        exmem_w = 1'b1;
      end
      default: begin
        state_nx  = RUN;
        lu_cnt_nx = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= RUN;
      lu_cnt <= 3'd0;
    end else begin
      state  <= state_nx;
      lu_cnt <= lu_cnt_nx;
    end
  end

  // Held in reset, every register stays loaded-disabled.
  assign pc_wen     = rst && pc_w;
  assign ifid_wen   = rst && ifid_w;
  assign ifid_flush = rst && ifid_f;
  assign idex_wen   = rst && idex_w;
  assign idex_flush = rst && idex_f;
  assign exmem_wen  = rst && exmem_w;
  assign halted     = rst && (state == HALT);

`ifdef STALL_COUNT_EN
  logic [15:0] cnt_q;
  logic        cnt_inc;

  assign cnt_inc = !pc_w && (state != HALT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 16'h0000;
    end else if (cnt_inc && cnt_q != 16'hFFFF) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Randomized bench for hazard_stall_ctrl against a remaining-bubble model.
// Two instances: default depth and a three-bubble load-use depth.
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       idex_memtoreg, idex_regwrite;
  logic [3:0] idex_rd, ifid_rs, ifid_rt;
  logic       ifid_uses_rs, ifid_uses_rt;
  logic       branch_taken, halt_id, mem_busy;

  logic [6:0]  vec [2];
  logic [15:0] cnt [2];

  logic pc_a, ifw_a, iff_a, idw_a, idf_a, exw_a, hlt_a;
  logic pc_b, ifw_b, iff_b, idw_b, idf_b, exw_b, hlt_b;

  int n_chk = 0;
  int n_err = 0;

  int m_left [2];
  bit m_halt [2];
  int m_cnt  [2];
  int m_n    [2];

  always #5 clk = ~clk;

  hazard_stall_ctrl u_dut (
    .clk(clk), .rst(rst),
    .idex_memtoreg(idex_memtoreg), .idex_regwrite(idex_regwrite),
    .idex_rd(idex_rd), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_uses_rs(ifid_uses_rs), .ifid_uses_rt(ifid_uses_rt),
    .branch_taken(branch_taken), .halt_id(halt_id),
    .mem_busy(mem_busy),
    .pc_wen(pc_a), .ifid_wen(ifw_a), .ifid_flush(iff_a),
    .idex_wen(idw_a), .idex_flush(idf_a), .exmem_wen(exw_a),
    .halted(hlt_a), .stall_cnt(cnt[0])
  );

  hazard_stall_ctrl #(.LOAD_STALL_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .idex_memtoreg(idex_memtoreg), .idex_regwrite(idex_regwrite),
    .idex_rd(idex_rd), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_uses_rs(ifid_uses_rs), .ifid_uses_rt(ifid_uses_rt),
    .branch_taken(branch_taken), .halt_id(halt_id),
    .mem_busy(mem_busy),
    .pc_wen(pc_b), .ifid_wen(ifw_b), .ifid_flush(iff_b),
    .idex_wen(idw_b), .idex_flush(idf_b), .exmem_wen(exw_b),
    .halted(hlt_b), .stall_cnt(cnt[1])
  );

  assign vec[0] = {pc_a, ifw_a, iff_a, idw_a, idf_a, exw_a, hlt_a};
  assign vec[1] = {pc_b, ifw_b, iff_b, idw_b, idf_b, exw_b, hlt_b};

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit hazard();
    if (!(idex_memtoreg && idex_regwrite)) return 1'b0;
    if (idex_rd == 0) return 1'b0;
    return (ifid_uses_rs && ifid_rs == idex_rd)
        || (ifid_uses_rt && ifid_rt == idex_rd);
  endfunction

  // 0 freeze, 1 squash, 2 bubble/hold, 3 advance
  function automatic int action(int i);
    if (mem_busy) return 0;
    if (m_halt[i]) return 2;
    if (branch_taken) return 1;
    if (m_left[i] > 0) return 2;
    if (halt_id || hazard()) return 2;
    return 3;
  endfunction

  function automatic logic [6:0] expect_vec(int i);
    logic [5:0] w;
    case (action(i))
      1: w = 6'b111111;
      2: w = 6'b000111;
      3: w = 6'b110101;
      default: w = 6'b000000;
    endcase
    return {w, m_halt[i]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_left[i] = 0;
      m_halt[i] = 1'b0;
      m_cnt[i]  = 0;
    end
  endtask

  task automatic model_tick();
    for (int i = 0; i < 2; i++) begin
      int a;
      a = action(i);
`ifdef STALL_COUNT_EN
      if (!m_halt[i] && (a == 0 || a == 2) && m_cnt[i] < 65535)
        m_cnt[i]++;
`endif
      if (mem_busy || m_halt[i]) continue;
      if (branch_taken) m_left[i] = 0;
      else if (m_left[i] > 0) m_left[i]--;
      else if (halt_id) m_halt[i] = 1'b1;
      else if (hazard()) m_left[i] = m_n[i] - 1;
    end
  endtask

  task automatic step(input bit busy, input bit br, input bit hlt,
                      input bit ld, input bit rw, input int rd,
                      input int rs, input int rt,
                      input bit urs, input bit urt);
    @(negedge clk);
    mem_busy      = busy;
    branch_taken  = br;
    halt_id       = hlt;
    idex_memtoreg = ld;
    idex_regwrite = rw;
    idex_rd       = 4'(rd);
    ifid_rs       = 4'(rs);
    ifid_rt       = 4'(rt);
    ifid_uses_rs  = urs;
    ifid_uses_rt  = urt;
    #1;
    check("ctl_n1", 32'(vec[0]), 32'(expect_vec(0)));
    check("ctl_n3", 32'(vec[1]), 32'(expect_vec(1)));
    check("cnt_n1", 32'(cnt[0]), 32'(m_cnt[0]));
    check("cnt_n3", 32'(cnt[1]), 32'(m_cnt[1]));
    @(posedge clk);
    model_tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    mem_busy = 1'b0; branch_taken = 1'b0; halt_id = 1'b0;
    idex_memtoreg = 1'b0; idex_regwrite = 1'b0;
    #1;
    check("rst_ctl", 32'(vec[0]), 32'h0);
    check("rst_ctl3", 32'(vec[1]), 32'h0);
    check("rst_cnt", 32'(cnt[0]), 32'h0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    m_n[0] = 1;
    m_n[1] = 3;
    rst = 1'b0;
    mem_busy = 1'b0; branch_taken = 1'b0; halt_id = 1'b0;
    idex_memtoreg = 1'b0; idex_regwrite = 1'b0;
    idex_rd = '0; ifid_rs = '0; ifid_rt = '0;
    ifid_uses_rs = 1'b0; ifid_uses_rt = 1'b0;
    model_reset();

    do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("run_after_rst", 32'(vec[0]), 32'b1101010);

    // load-use on rs=3, then rd=0 never stalls
    step(0, 0, 0, 1, 1, 3, 3, 5, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0, 0, 1, 1);
    check("rd0_nostall", 32'(pc_a), 32'h1);

    // three-bubble hazard with a two-cycle freeze inside
    step(0, 0, 0, 1, 1, 3, 3, 0, 1, 0);
    step(1, 0, 0, 1, 1, 3, 3, 0, 1, 0);
    step(1, 0, 0, 1, 1, 3, 3, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // branch beats hazard and halt in the same cycle
    step(0, 1, 1, 1, 1, 2, 2, 2, 1, 1);
    check("br_flush", 32'({pc_a, iff_a, idf_a}), 32'b111);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("br_nohalt", 32'(hlt_a), 32'h0);

    // halt is sticky, ignores branch, cleared by reset
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("halt_sticky", 32'({hlt_a, pc_a}), 32'b10);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("halt_cleared", 32'(hlt_a), 32'h0);

    for (int seg = 0; seg < 15; seg++) begin
      do_reset();
      for (int c = 0; c < 150; c++) begin
        step($urandom_range(0, 99) < 20,
             $urandom_range(0, 99) < 10,
             $urandom_range(0, 199) < 3,
             $urandom_range(0, 99) < 60,
             $urandom_range(0, 99) < 80,
             int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline control unit that drives the write-enable and flush inputs of the PC register and the IF_ID, ID_EX and EX_MEM pipeline registers.
- It sits beside the ID stage. It watches the instruction in IF_ID and the destination/control bits already latched in ID_EX, and it decides each cycle whether the pipeline advances, stalls, inserts a bubble, squashes wrong-path instructions or halts.
- Freeze, load-use and halt behaviour are sequential, tracked by a small state machine and a stall counter.

Parameters:
- LOAD_STALL_CYCLES, 1, number of bubbles inserted per load-use hazard (1..7).
- REG_ADDR_W, 4, register-select width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- idex_memtoreg  input  1  instruction in ID_EX is a load.
- idex_regwrite  input  1  instruction in ID_EX writes a register.
- idex_rd  input  REG_ADDR_W  ID_EX reg_write_select.
- ifid_rs  input  REG_ADDR_W  source 1 of instruction in IF_ID.
- ifid_rt  input  REG_ADDR_W  source 2 of instruction in IF_ID.
- ifid_uses_rs  input  1  IF_ID instruction reads rs.
- ifid_uses_rt  input  1  IF_ID instruction reads rt.
- branch_taken  input  1  EX resolved a taken branch/jump this cycle.
- halt_id  input  1  IF_ID instruction is HLT.
- mem_busy  input  1  data memory access not complete.
- pc_wen  output  1  PC register write enable.
- ifid_wen  output  1  IF_ID write enable.
- ifid_flush  output  1  IF_ID loads NOP.
- idex_wen  output  1  ID_EX write enable.
- idex_flush  output  1  ID_EX loads bubble (all control bits 0).
- exmem_wen  output  1  EX_MEM write enable.
- halted  output  1  pipeline frozen by HLT.
- stall_cnt  output  16  stall-cycle counter (see Optional Feature).

Behaviour:
- States: RUN, LU_STALL, HALT. Internal counter lu_cnt, 3 bits.
- Reset (rst=0, asynchronous):
  - State goes to RUN, lu_cnt=0, stall_cnt=0.
  - All wen outputs 0, all flush outputs 0, halted 0.
  - On the first edge after release, normal decode applies.
- Hazard term: hz = idex_memtoreg & idex_regwrite & idex_rd!=0 & ((ifid_uses_rs & ifid_rs==idex_rd) | (ifid_uses_rt & ifid_rt==idex_rd)). Register 0 never causes a hazard.
- Outputs are decoded combinationally from state and inputs. Priority, highest first:
  1. mem_busy=1: freeze. All four wen=0, no flush, state and lu_cnt unchanged. This applies in every state, including an LU_STALL in progress.
  2. branch_taken=1 (RUN or LU_STALL):
     - pc_wen=1, ifid_wen=1, ifid_flush=1, idex_wen=1, idex_flush=1, exmem_wen=1.
     - Next state RUN, lu_cnt cleared.
     - A pending halt_id or hz in the same cycle is ignored, because that instruction is wrong-path.
  3. halt_id=1 in RUN:
     - pc_wen=0, ifid_wen=0, idex_wen=1, idex_flush=1, exmem_wen=1.
     - Next state HALT.
  4. hz=1 in RUN:
     - pc_wen=0, ifid_wen=0, idex_wen=1, idex_flush=1, exmem_wen=1.
     - If LOAD_STALL_CYCLES>1, go to LU_STALL with lu_cnt=LOAD_STALL_CYCLES-1; otherwise stay in RUN.
  5. Otherwise: all wen=1, no flush.
- LU_STALL (no freeze, no branch):
  - Same outputs as priority 4.
  - lu_cnt decrements each cycle; go to RUN when lu_cnt reaches 1.
  - hz is not re-evaluated while in LU_STALL.
- HALT:
  - pc_wen=0, ifid_wen=0, idex_wen=1, idex_flush=1, exmem_wen=1. Older instructions drain.
  - halted=1.
  - Left only by reset; branch_taken is ignored in HALT.
- Simultaneous mem_busy and branch_taken: the freeze wins. The branch is applied on the first cycle mem_busy=0, since EX holds branch_taken stable while frozen.

Optional Feature:
- Macro STALL_COUNT_EN.
- Defined: stall_cnt increments by 1 every cycle with pc_wen=0 while not in HALT (freeze, load-use bubble, halt-entry cycle). It saturates at 16'hFFFF and is cleared by reset.
- Undefined: stall_cnt is tied to 16'h0000 and no counter flops are built.

Test Plan:
- Reset held then released: all wen/flush 0 during reset; with no hazard inputs, the first cycle after release gives pc_wen=ifid_wen=idex_wen=exmem_wen=1 and halted=0.
- idex_memtoreg=1, idex_regwrite=1, idex_rd=3, ifid_rs=3, ifid_uses_rs=1, default parameter: exactly one cycle of pc_wen=0, ifid_wen=0, idex_flush=1, then all wen=1. Repeat with idex_rd=0: no stall.
- LOAD_STALL_CYCLES=3 with the same hazard: 3 consecutive bubble cycles. Assert mem_busy=1 for 2 cycles in the middle: all wen=0 for those 2 cycles, and the bubble count is still 3 in total.
- branch_taken=1 in the same cycle as hz=1 and halt_id=1: ifid_flush=idex_flush=1 and pc_wen=1; next cycle is RUN with halted=0.
- halt_id=1: from the next cycle halted=1 and pc_wen=0 permanently. A later branch_taken=1 has no effect. Asserting rst=0 returns to RUN.
- With STALL_COUNT_EN defined: one load-use bubble plus 4 mem_busy cycles gives stall_cnt=5. Preloaded at 16'hFFFF, the counter holds that value.
